// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimator front end.
// Holds the memory geometry, motion-vector width, default run latency
// and the loader state encoding.
package me_pkg;

  localparam int unsigned R_DEPTH            = 256;   // 16x16 reference block
  localparam int unsigned S_DEPTH            = 961;   // 31x31 search window
  localparam int unsigned BLK_W              = 16;
  localparam int unsigned WIN_W              = 31;
  localparam int unsigned MV_W               = 4;
  localparam int unsigned ME_LATENCY_DEFAULT = 4500;

  typedef enum logic [1:0] {
    LOAD_R,
    LOAD_S,
    RUN,
    CAPTURE
  } me_state_e;

endpackage

// File: rtl/me_dualread_mem.sv
// DEPTH x DW storage array with one synchronous write port and two
// asynchronous read ports. Reads of addresses at or beyond DEPTH return 0.
// Ports:
//   clk_i                     write clock (rising edge)
//   we_i, wr_addr_i, wr_data_i write port
//   rd_addr_a_i / rd_data_a_o combinational read port A
//   rd_addr_b_i / rd_data_b_o combinational read port B
module me_dualread_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_a_i,
  output logic [DW-1:0] rd_data_a_o,
  input  logic [AW-1:0] rd_addr_b_i,
  output logic [DW-1:0] rd_data_b_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_a_o = '0;
    rd_data_b_o = '0;
    if (32'(rd_addr_a_i) < DEPTH) rd_data_a_o = mem_q[rd_addr_a_i];
    if (32'(rd_addr_b_i) < DEPTH) rd_data_b_o = mem_q[rd_addr_b_i];
  end

endmodule

// File: rtl/me_frame_loader.sv
// Front end of the motion estimator: loads a byte-serial pixel stream
// into the reference block (R) and search window (S) memories, serves the
// estimator's asynchronous read ports, holds start high for ME_LATENCY
// cycles and then captures the motion vector.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   pix_in/pix_valid/pix_ready  pixel stream handshake (R first, then S)
//   start                   level start to the estimator
//   AddressR -> R           reference block read
//   AddressS1 -> s1, AddressS2 -> s2  search window reads (0 beyond 960)
//   motionx/motiony         estimator result
//   mv_x/mv_y/mv_valid      captured result and one-cycle update pulse
module me_frame_loader
  import me_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned ME_LATENCY = ME_LATENCY_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [DW-1:0]   pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic            start,
  input  logic [7:0]      AddressR,
  input  logic [9:0]      AddressS1,
  input  logic [9:0]      AddressS2,
  output logic [DW-1:0]   R,
  output logic [DW-1:0]   s1,
  output logic [DW-1:0]   s2,
  input  logic [MV_W-1:0] motionx,
  input  logic [MV_W-1:0] motiony,
  output logic [MV_W-1:0] mv_x,
  output logic [MV_W-1:0] mv_y,
  output logic            mv_valid
);

  localparam int unsigned CNT_W = $clog2(S_DEPTH);
  localparam int unsigned RUN_W = $clog2(ME_LATENCY);

  me_state_e        state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             pix_ready_q, pix_ready_d;
  logic             start_q, start_d;
  logic [MV_W-1:0]  mv_x_q, mv_x_d;
  logic [MV_W-1:0]  mv_y_q, mv_y_d;
  logic             mv_valid_q, mv_valid_d;

  logic xfer;
  logic r_we, s_we;
  logic [DW-1:0] unused_r_rd_b;

  assign xfer = pix_valid && pix_ready_q;
  // Reset takes priority over a coincident pixel: no write on that edge.
  assign r_we = xfer && !reset && (state_q == LOAD_R);
  assign s_we = xfer && !reset && (state_q == LOAD_S);

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    run_cnt_d   = run_cnt_q;
    pix_ready_d = pix_ready_q;
    start_d     = start_q;
    mv_x_d      = mv_x_q;
    mv_y_d      = mv_y_q;
    mv_valid_d  = 1'b0;
    unique case (state_q)
      LOAD_R: begin
        pix_ready_d = 1'b1;
        if (xfer) begin
          if (wr_cnt_q == CNT_W'(R_DEPTH - 1)) begin
            wr_cnt_d = '0;
            state_d  = LOAD_S;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      LOAD_S: begin
        pix_ready_d = 1'b1;
        if (xfer) begin
          if (wr_cnt_q == CNT_W'(S_DEPTH - 1)) begin
            wr_cnt_d    = '0;
            state_d     = RUN;
            pix_ready_d = 1'b0;
            start_d     = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        start_d     = 1'b1;
        pix_ready_d = 1'b0;
        run_cnt_d   = run_cnt_q + 1'b1;
        if (run_cnt_q == RUN_W'(ME_LATENCY - 1)) begin
          state_d = CAPTURE;
          start_d = 1'b0;
        end
      end
      CAPTURE: begin
        mv_x_d      = motionx;
        mv_y_d      = motiony;
        mv_valid_d  = 1'b1;
        run_cnt_d   = '0;
        start_d     = 1'b0;
        pix_ready_d = 1'b1;
        state_d     = LOAD_R;
      end
      default: state_d = LOAD_R;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LOAD_R;
      wr_cnt_q    <= '0;
      run_cnt_q   <= '0;
      pix_ready_q <= 1'b1;
      start_q     <= 1'b0;
      mv_x_q      <= '0;
      mv_y_q      <= '0;
      mv_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      run_cnt_q   <= run_cnt_d;
      pix_ready_q <= pix_ready_d;
      start_q     <= start_d;
      mv_x_q      <= mv_x_d;
      mv_y_q      <= mv_y_d;
      mv_valid_q  <= mv_valid_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign start     = start_q;
  assign mv_x      = mv_x_q;
  assign mv_y      = mv_y_q;
  assign mv_valid  = mv_valid_q;

  me_dualread_mem #(
    .DEPTH(R_DEPTH),
    .DW   (DW),
    .AW   (8)
  ) u_r_mem (
    .clk_i      (clock),
    .we_i       (r_we),
    .wr_addr_i  (wr_cnt_q[7:0]),
    .wr_data_i  (pix_in),
    .rd_addr_a_i(AddressR),
    .rd_data_a_o(R),
    .rd_addr_b_i('0),
    .rd_data_b_o(unused_r_rd_b)
  );

  me_dualread_mem #(
    .DEPTH(S_DEPTH),
    .DW   (DW),
    .AW   (CNT_W)
  ) u_s_mem (
    .clk_i      (clock),
    .we_i       (s_we),
    .wr_addr_i  (wr_cnt_q),
    .wr_data_i  (pix_in),
    .rd_addr_a_i(AddressS1),
    .rd_data_a_o(s1),
    .rd_addr_b_i(AddressS2),
    .rd_data_b_o(s2)
  );

endmodule

// File: tb/tb_me_frame_loader.sv
// Self-checking bench for me_frame_loader with a short run latency.
// Memory contents are tracked in model arrays; expected motion vectors
// are queued when driven and compared when mv_valid pulses.
module tb_me_frame_loader;

  localparam int unsigned ME_LAT  = 10;
  localparam int unsigned R_BYTES = 256;
  localparam int unsigned S_BYTES = 961;
  localparam int unsigned ALL     = R_BYTES + S_BYTES;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic       start;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [7:0] R, s1, s2;
  logic [3:0] motionx, motiony;
  logic [3:0] mv_x, mv_y;
  logic       mv_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned pulses   = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  last_x = '0, last_y = '0;

  logic [7:0] r_model [R_BYTES];
  logic [7:0] s_model [S_BYTES];
  logic [7:0] sb_q [$];

  always #5 clock = ~clock;

  me_frame_loader #(
    .DW        (8),
    .ME_LATENCY(ME_LAT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .start    (start),
    .AddressR (AddressR),
    .AddressS1(AddressS1),
    .AddressS2(AddressS2),
    .R        (R),
    .s1       (s1),
    .s2       (s2),
    .motionx  (motionx),
    .motiony  (motiony),
    .mv_x     (mv_x),
    .mv_y     (mv_y),
    .mv_valid (mv_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result monitor: every mv_valid pulse must match the oldest queued vector.
  always @(negedge clock) begin
    if (!reset && mv_valid) begin
      logic [7:0] e;
      pulses++;
      check_eq("mv_valid_width", 32'(prev_valid), 32'(0));
      if (sb_q.size() == 0) begin
        check_eq("mv_unexpected", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check_eq("mv_x", 32'(mv_x), 32'(e[7:4]));
        check_eq("mv_y", 32'(mv_y), 32'(e[3:0]));
      end
    end
    prev_valid = mv_valid;
  end

  // Stream nbytes accepted pixels of value (i+seed) mod 256. Entered and left at a negedge.
  task automatic load_stream(input int unsigned seed, input bit gaps,
                             input int unsigned nbytes, input bit expect_start);
    int unsigned acc = 0;
    int unsigned cyc = 0;
    bit early = 0, drop = 0, tog = 1;
    while (acc < nbytes && cyc < 5000) begin
      if (start) early = 1;
      if (!pix_ready) drop = 1;
      pix_valid = gaps ? tog : 1'b1;
      tog = !tog;
      pix_in = 8'((acc + seed) % 256);
      if (pix_valid && pix_ready) begin
        if (acc < R_BYTES) r_model[acc] = pix_in;
        else               s_model[acc - R_BYTES] = pix_in;
        acc++;
      end
      @(negedge clock);
      cyc++;
    end
    pix_valid = 1'b0;
    check_eq("load_accepted", acc, nbytes);
    check_eq("load_start_early", 32'(early), 32'(0));
    check_eq("load_ready_drop", 32'(drop), 32'(0));
    if (expect_start) begin
      check_eq("load_start_rise", 32'(start), 32'(1));
      check_eq("load_ready_low", 32'(pix_ready), 32'(0));
    end
  endtask

  // Entered at the first negedge with start high.
  task automatic run_and_capture(input logic [3:0] x, input logic [3:0] y, input bit hold_valid);
    int unsigned n = 1;
    int unsigned guard = 0;
    check_eq("mv_hold_x", 32'(mv_x), 32'(last_x));
    check_eq("mv_hold_y", 32'(mv_y), 32'(last_y));
    motionx = x;
    motiony = y;
    sb_q.push_back({x, y});
    if (hold_valid) begin
      pix_valid = 1'b1;
      pix_in    = 8'hAA;
    end
    while (guard < 100) begin
      @(negedge clock);
      guard++;
      if (start) n++;
      else break;
    end
    check_eq("start_len", n, ME_LAT);
    check_eq("ready_in_capture", 32'(pix_ready), 32'(0));
    check_eq("mv_hold_pre_cap", 32'(mv_x), 32'(last_x));
    pix_valid = 1'b0;
    @(negedge clock);
    check_eq("ready_after_capture", 32'(pix_ready), 32'(1));
    check_eq("start_after_capture", 32'(start), 32'(0));
    last_x = x;
    last_y = y;
    @(negedge clock);
  endtask

  task automatic verify_mem();
    for (int unsigned a = 0; a < R_BYTES; a++) begin
      AddressR = 8'(a);
      #1;
      check_eq("R_read", 32'(R), 32'(r_model[a]));
    end
    for (int unsigned a = 0; a < S_BYTES; a++) begin
      AddressS1 = 10'(a);
      AddressS2 = 10'(S_BYTES - 1 - a);
      #1;
      check_eq("s1_read", 32'(s1), 32'(s_model[a]));
      check_eq("s2_read", 32'(s2), 32'(s_model[S_BYTES - 1 - a]));
    end
    AddressS1 = 10'd961;
    AddressS2 = 10'd1023;
    #1;
    check_eq("s1_oob", 32'(s1), 32'(0));
    check_eq("s2_oob", 32'(s2), 32'(0));
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    pix_valid = 1'b0;
    pix_in = '0;
    AddressR = '0;
    AddressS1 = '0;
    AddressS2 = '0;
    motionx = '0;
    motiony = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_ready", 32'(pix_ready), 32'(1));
    check_eq("rst_start", 32'(start), 32'(0));
    check_eq("rst_mv_x", 32'(mv_x), 32'(0));
    check_eq("rst_mv_y", 32'(mv_y), 32'(0));
    check_eq("rst_mv_valid", 32'(mv_valid), 32'(0));
    reset = 1'b0;
    @(negedge clock);

    // Full stream without gaps; pixels offered during RUN must be ignored.
    load_stream(0, 1'b0, ALL, 1'b1);
    run_and_capture(4'h7, 4'h9, 1'b1);
    verify_mem();
    AddressR = 8'h05;
    AddressS1 = 10'd0;
    AddressS2 = 10'd960;
    #1;
    check_eq("R_05", 32'(R), 32'h05);
    check_eq("s1_0", 32'(s1), 32'h00);
    check_eq("s2_960", 32'(s2), 32'hC0);
    @(negedge clock);

    // Second stream with valid gaps, back-to-back run.
    load_stream(17, 1'b1, ALL, 1'b1);
    run_and_capture(4'h3, 4'hC, 1'b0);
    verify_mem();

    // Reset during RUN at run_cnt == 3.
    load_stream(9, 1'b0, ALL, 1'b1);
    motionx = 4'hF;
    motiony = 4'hF;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("runrst_start", 32'(start), 32'(0));
    check_eq("runrst_ready", 32'(pix_ready), 32'(1));
    check_eq("runrst_mv_valid", 32'(mv_valid), 32'(0));
    check_eq("runrst_mv_x", 32'(mv_x), 32'(0));
    check_eq("runrst_mv_y", 32'(mv_y), 32'(0));
    reset = 1'b0;
    last_x = '0;
    last_y = '0;
    @(negedge clock);

    // Partial load, then reset with a coincident pixel that must not be written.
    load_stream(50, 1'b0, 300, 1'b0);
    reset = 1'b1;
    pix_valid = 1'b1;
    pix_in = 8'hEE;
    @(negedge clock);
    reset = 1'b0;
    pix_valid = 1'b0;
    AddressS1 = 10'd44;
    #1;
    check_eq("rst_wins_no_write", 32'(s1), 32'(s_model[44]));
    check_eq("partial_rst_start", 32'(start), 32'(0));
    @(negedge clock);

    load_stream(100, 1'b0, ALL, 1'b1);
    run_and_capture(4'hA, 4'h5, 1'b0);
    verify_mem();

    check_eq("mv_pulses", pulses, 3);
    check_eq("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
